// File: rtl/axi4_lite_slave_mem_pkg.sv
// Shared definitions for the AXI4-Lite slave memory: response codes,
// channel FSM state types and the byte-offset helper.
package axi4_lite_slave_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_RESP = 1'b1} rd_state_t;

  // Number of low address bits that select a byte inside one data word.
  function automatic int unsigned byte_shift(input int unsigned data_width);
    return $clog2(data_width / 32'd8);
  endfunction

endpackage

// File: rtl/axi4_lite_slave_mem_if.sv
// AXI4-Lite bus bundle between master and the slave memory.
interface axi4_lite_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi4_lite_strb_mem.sv
// Word array with async clear, one byte-strobed write port and one registered
// read port; a same-edge read of the written word returns the old contents.
module axi4_lite_strb_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64,
  localparam int unsigned IDX_W     = $clog2(DEPTH),
  localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_W-1:0]     wr_strb,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Storage: cleared on reset, byte lanes updated under strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wr_strb[b]) begin
          mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read register: loads only on a captured read, so it holds while the response waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= rd_zero ? {DATA_WIDTH{1'b0}} : mem_r[rd_idx];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave memory: address decode plus independent write and read
// channel FSMs in front of a byte-strobed word array.
module axi4_lite_slave_mem
  import axi4_lite_slave_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input logic                  ACLK,
  input logic                  ARESETN,
  axi4_lite_slave_mem_if.slave bus
);

  localparam int unsigned           SHIFT  = byte_shift(DATA_WIDTH);
  localparam int unsigned           IDX_W  = $clog2(DEPTH);
  localparam int unsigned           STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   SPAN   = (ADDR_WIDTH+1)'(DEPTH * STRB_W);

  // Addresses below the base underflow and are treated as out of range.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> SHIFT);
  endfunction

  wr_state_t               wr_state_r;
  logic                    aw_held_r, w_held_r;
  logic [ADDR_WIDTH-1:0]   awaddr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [STRB_W-1:0]       wstrb_r;
  logic                    awready_r, wready_r, bvalid_r;
  logic [1:0]              bresp_r;
  rd_state_t               rd_state_r;
  logic                    arready_r, rvalid_r;
  logic [1:0]              rresp_r;
  logic [DATA_WIDTH-1:0]   rdata_s;

  logic                    aw_hs_s, w_hs_s, aw_have_s, w_have_s, commit_s, wr_ok_s;
  logic                    ar_hs_s, rd_ok_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;
  logic [STRB_W-1:0]       wr_strb_s;

  // A channel counts as present if it was captured earlier or handshakes on this edge.
  assign aw_hs_s   = bus.AWVALID && awready_r;
  assign w_hs_s    = bus.WVALID && wready_r;
  assign aw_have_s = aw_held_r || aw_hs_s;
  assign w_have_s  = w_held_r || w_hs_s;
  assign wr_addr_s = aw_held_r ? awaddr_r : bus.AWADDR;
  assign wr_data_s = w_held_r ? wdata_r : bus.WDATA;
  assign wr_strb_s = w_held_r ? wstrb_r : bus.WSTRB;
  assign commit_s  = (wr_state_r == WR_IDLE) && aw_have_s && w_have_s;
  assign wr_ok_s   = in_range(wr_addr_s);
  assign ar_hs_s   = bus.ARVALID && arready_r;
  assign rd_ok_s   = in_range(bus.ARADDR);

  // Write channel FSM: collects AW and W in any order, commits, then waits for BREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_r <= WR_IDLE;
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      awaddr_r   <= {ADDR_WIDTH{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      wstrb_r    <= {STRB_W{1'b0}};
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
    end else begin
      case (wr_state_r)
        WR_IDLE: begin
          if (commit_s) begin
            wr_state_r <= WR_RESP;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b1;
            bresp_r    <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
          end else begin
            awready_r <= !aw_have_s;
            wready_r  <= !w_have_s;
            if (aw_hs_s) begin
              aw_held_r <= 1'b1;
              awaddr_r  <= bus.AWADDR;
            end
            if (w_hs_s) begin
              w_held_r <= 1'b1;
              wdata_r  <= bus.WDATA;
              wstrb_r  <= bus.WSTRB;
            end
          end
        end
        WR_RESP: begin
          if (bus.BREADY) begin
            wr_state_r <= WR_IDLE;
            bvalid_r   <= 1'b0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
          end
        end
        default: begin
          wr_state_r <= WR_IDLE;
          bvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  // Read channel FSM: one outstanding read, response held until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_r <= RD_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rresp_r    <= RESP_OKAY;
    end else begin
      case (rd_state_r)
        RD_IDLE: begin
          if (ar_hs_s) begin
            rd_state_r <= RD_RESP;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b1;
            rresp_r    <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
          end else begin
            arready_r <= 1'b1;
          end
        end
        RD_RESP: begin
          if (bus.RREADY) begin
            rd_state_r <= RD_IDLE;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
          end
        end
        default: begin
          rd_state_r <= RD_IDLE;
          rvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  axi4_lite_strb_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (commit_s && wr_ok_s),
    .wr_idx  (word_idx(wr_addr_s)),
    .wr_data (wr_data_s),
    .wr_strb (wr_strb_s),
    .rd_en   (ar_hs_s),
    .rd_zero (!rd_ok_s),
    .rd_idx  (word_idx(bus.ARADDR)),
    .rd_data (rdata_s)
  );

  assign bus.AWREADY = awready_r;
  assign bus.WREADY  = wready_r;
  assign bus.BVALID  = bvalid_r;
  assign bus.BRESP   = bresp_r;
  assign bus.ARREADY = arready_r;
  assign bus.RVALID  = rvalid_r;
  assign bus.RRESP   = rresp_r;
  assign bus.RDATA   = rdata_s;

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Randomised self-checking bench for axi4_lite_slave_mem against a word-array
// reference memory.
module tb_axi4_lite_slave_mem;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic ACLK;
  logic ARESETN;
  int   n_checks;
  int   n_fail;
  logic [31:0] model_mem [DEPTH];

  axi4_lite_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_slave_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_in_range(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead, input int b_hold);
    logic [1:0]  exp_resp;
    logic [31:0] w;
    fork
      begin
        if (lead > 0) repeat (lead) @(negedge ACLK);
        bus.AWADDR  = addr;
        bus.AWVALID = 1'b1;
        for (int t = 0; t < 50 && !bus.AWREADY; t++) @(negedge ACLK);
        check_eq("awready_wait", bus.AWREADY, 1'b1);
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
      end
      begin
        if (lead < 0) repeat (-lead) @(negedge ACLK);
        bus.WDATA  = data;
        bus.WSTRB  = strb;
        bus.WVALID = 1'b1;
        for (int t = 0; t < 50 && !bus.WREADY; t++) @(negedge ACLK);
        check_eq("wready_wait", bus.WREADY, 1'b1);
        @(negedge ACLK);
        bus.WVALID = 1'b0;
        if (lead >= 1) check_eq("wready_low_waiting_aw", bus.WREADY, 1'b0);
      end
    join
    exp_resp = model_in_range(addr) ? 2'b00 : 2'b10;
    if (model_in_range(addr)) begin
      w = model_mem[model_idx(addr)];
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      end
      model_mem[model_idx(addr)] = w;
    end
    check_eq("b_latency", bus.BVALID, 1'b1);
    check_eq("bresp", bus.BRESP, exp_resp);
    for (int k = 0; k < b_hold; k++) begin
      @(negedge ACLK);
      check_eq("bvalid_hold", bus.BVALID, 1'b1);
      check_eq("bresp_hold", bus.BRESP, exp_resp);
      check_eq("awready_hold", bus.AWREADY, 1'b0);
    end
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    bus.BREADY = 1'b0;
    check_eq("bvalid_done", bus.BVALID, 1'b0);
    check_eq("awready_back", bus.AWREADY, 1'b1);
    check_eq("wready_back", bus.WREADY, 1'b1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_hold);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = model_in_range(addr) ? model_mem[model_idx(addr)] : 32'h0;
    exp_resp = model_in_range(addr) ? 2'b00 : 2'b10;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    for (int t = 0; t < 50 && !bus.ARREADY; t++) @(negedge ACLK);
    check_eq("arready_wait", bus.ARREADY, 1'b1);
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    check_eq("r_latency", bus.RVALID, 1'b1);
    check_eq("rdata", bus.RDATA, exp_data);
    check_eq("rresp", bus.RRESP, exp_resp);
    for (int k = 0; k < r_hold; k++) begin
      @(negedge ACLK);
      check_eq("rvalid_hold", bus.RVALID, 1'b1);
      check_eq("rdata_hold", bus.RDATA, exp_data);
      check_eq("arready_hold", bus.ARREADY, 1'b0);
    end
    bus.RREADY = 1'b1;
    @(negedge ACLK);
    bus.RREADY = 1'b0;
    check_eq("rvalid_done", bus.RVALID, 1'b0);
    check_eq("arready_back", bus.ARREADY, 1'b1);
  endtask

  task automatic sweep_memory();
    for (int i = 0; i < int'(DEPTH); i++) axi_read(BASE + 32'(i * 4), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
    ARESETN     = 1'b0;
    bus.AWADDR  = 32'h0;  bus.AWVALID = 1'b0;
    bus.WDATA   = 32'h0;  bus.WSTRB   = 4'h0;  bus.WVALID = 1'b0;
    bus.BREADY  = 1'b0;
    bus.ARADDR  = 32'h0;  bus.ARVALID = 1'b0;  bus.RREADY = 1'b0;

    repeat (3) @(negedge ACLK);
    check_eq("rst_awready", bus.AWREADY, 1'b0);
    check_eq("rst_wready", bus.WREADY, 1'b0);
    check_eq("rst_arready", bus.ARREADY, 1'b0);
    check_eq("rst_bvalid", bus.BVALID, 1'b0);
    check_eq("rst_rvalid", bus.RVALID, 1'b0);
    check_eq("rst_bresp", bus.BRESP, 2'b00);
    check_eq("rst_rresp", bus.RRESP, 2'b00);
    check_eq("rst_rdata", bus.RDATA, 32'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check_eq("post_rst_awready", bus.AWREADY, 1'b1);
    check_eq("post_rst_arready", bus.ARREADY, 1'b1);

    // Directed cases
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    axi_read(32'h10, 0);
    axi_write(32'h20, 32'hAABB_CCDD, 4'hF, 0, 0);
    axi_write(32'h20, 32'h1122_3344, 4'b0101, 2, 0);
    axi_read(32'h20, 0);
    check_eq("strb_merge", model_mem[8], 32'hAA22_CC44);
    axi_write(32'h24, 32'h5555_5555, 4'h0, -1, 0);
    axi_read(32'h24, 0);
    axi_write(32'h100, 32'hCAFE_F00D, 4'hF, 0, 0);
    axi_read(32'h100, 0);
    axi_write(32'hFFFF_FFF0, 32'h1234_5678, 4'hF, 1, 1);
    axi_read(32'hFFFF_FFFC, 1);
    axi_write(32'h40, 32'h0BAD_CAFE, 4'hF, 0, 5);
    axi_read(32'h43, 5);

    // Write commit and read capture on the same edge
    axi_write(32'h30, 32'h1, 4'hF, 0, 0);
    bus.AWADDR = 32'h30;  bus.WDATA = 32'h2;  bus.WSTRB = 4'hF;  bus.ARADDR = 32'h30;
    bus.AWVALID = 1'b1;  bus.WVALID = 1'b1;  bus.ARVALID = 1'b1;
    @(negedge ACLK);
    bus.AWVALID = 1'b0;  bus.WVALID = 1'b0;  bus.ARVALID = 1'b0;
    check_eq("coll_bvalid", bus.BVALID, 1'b1);
    check_eq("coll_rvalid", bus.RVALID, 1'b1);
    check_eq("coll_old_data", bus.RDATA, 32'h1);
    model_mem[12] = 32'h2;
    bus.BREADY = 1'b1;  bus.RREADY = 1'b1;
    @(negedge ACLK);
    bus.BREADY = 1'b0;  bus.RREADY = 1'b0;
    axi_read(32'h30, 0);

    // Reset while W captured but AW pending
    bus.WDATA = 32'h7777_7777;  bus.WSTRB = 4'hF;  bus.WVALID = 1'b1;
    for (int t = 0; t < 50 && !bus.WREADY; t++) @(negedge ACLK);
    @(negedge ACLK);
    bus.WVALID = 1'b0;
    check_eq("pend_wready", bus.WREADY, 1'b0);
    ARESETN = 1'b0;
    #1;
    check_eq("async_rst_awready", bus.AWREADY, 1'b0);
    check_eq("async_rst_wready", bus.WREADY, 1'b0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    check_eq("rel_awready", bus.AWREADY, 1'b0);
    @(negedge ACLK);
    check_eq("rel_awready_up", bus.AWREADY, 1'b1);
    check_eq("rel_wready_up", bus.WREADY, 1'b1);
    check_eq("rel_arready_up", bus.ARREADY, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      check_eq("no_stale_bvalid", bus.BVALID, 1'b0);
    end
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
    axi_read(32'h10, 0);
    axi_read(32'h30, 0);

    // Randomised traffic against the reference memory
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 32'h13F));
      if ($urandom_range(0, 1) == 0)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
      else
        axi_read(a, int'($urandom_range(0, 2)));
    end
    sweep_memory();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
